// File: rtl/tmds_pkg.sv
// tmds_pkg: shared types, code-word constants and helpers for the TMDS lane
// encoder (tmds_lane, tmds_lane_array).
//   mode_t       period type presented to every lane each pixel clock
//   CTRL_TOKEN   2b control-period code words indexed by {c1,c0}
//   VID_GB_A/B   video guard-band words (even / odd lanes)
//   TERC4_LUT    4b data-island code words
//   popcount8()  number of ones in a byte
package tmds_pkg;

  typedef enum logic [2:0] {
    CTRL   = 3'd0,
    VIDEO  = 3'd1,
    VID_GB = 3'd2,
    DI_GB  = 3'd3,
    ISLAND = 3'd4
  } mode_t;

  localparam logic [9:0] CTRL_TOKEN [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  localparam logic [9:0] VID_GB_A = 10'h2CC;
  localparam logic [9:0] VID_GB_B = 10'h133;

  localparam logic [9:0] TERC4_LUT [16] = '{
    10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
    10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3
  };

  function automatic logic [3:0] popcount8(input logic [7:0] b);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, b[i]};
    return n;
  endfunction

endpackage

// File: rtl/tmds_lane.sv
// tmds_lane: one TMDS lane, four register stages from data/terc4 to tmds.
//   clk, rst  pixel clock, synchronous active-high reset
//   data      video byte (enters S1)
//   terc4     data-island nibble (enters S1, delayed alongside the byte)
//   mode      period type already aligned to S4 by the caller
//   ctrl      {c1,c0} already aligned to S4; lane 0 carries {vsync,hsync}
//   tmds      registered 10-bit code word, bit 0 sent first
//   disp      running disparity (only with TMDS_DISP_MON_EN defined)
// Optional feature macro: TMDS_DISP_MON_EN.
// There is no valid/ready handshake: every stage advances on every clock,
// so a word entering S1 leaves S4 exactly four clocks later.
module tmds_lane
  import tmds_pkg::*;
#(
  parameter int LANE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic [3:0] terc4,
  input  mode_t      mode,
  input  logic [1:0] ctrl,
  output logic [9:0] tmds
`ifdef TMDS_DISP_MON_EN
  ,
  output logic [4:0] disp
`endif
);

  // S1
  logic [7:0] d1;
  logic [3:0] n1;
  logic [3:0] t1;
  // S2
  logic [8:0] qm_c;
  logic       dec1;
  logic [8:0] qm2;
  logic [3:0] t2;
  // S3
  logic [8:0] qm3;
  logic [3:0] nq3;
  logic [3:0] t3;
  // S4
  logic [9:0] word_nxt;
  logic [4:0] cnt;
  logic [4:0] cnt_nxt;
  logic [4:0] two_n;
  logic       q8;
  logic       cnt_pos;
  logic       cnt_neg;

  // Transition-minimising stage: XNOR chain for ones-heavy bytes.
  always_comb begin
    qm_c    = '0;
    dec1    = (n1 > 4'd4) || ((n1 == 4'd4) && !d1[0]);
    qm_c[0] = d1[0];
    for (int i = 1; i < 8; i++) begin
      qm_c[i] = dec1 ? ~(qm_c[i-1] ^ d1[i]) : (qm_c[i-1] ^ d1[i]);
    end
    qm_c[8] = ~dec1;
  end

  // Output word and disparity update. cnt is 5-bit two's complement and
  // all arithmetic wraps mod 32; non-video periods restart it at zero.
  always_comb begin
    word_nxt = CTRL_TOKEN[ctrl];
    cnt_nxt  = '0;
    q8       = qm3[8];
    two_n    = {nq3, 1'b0};
    cnt_neg  = cnt[4];
    cnt_pos  = !cnt[4] && (cnt != 5'd0);
    case (mode)
      VIDEO: begin
        if ((cnt == 5'd0) || (nq3 == 4'd4)) begin
          word_nxt = {~q8, q8, qm3[7:0] ^ {8{~q8}}};
          cnt_nxt  = q8 ? (cnt + two_n - 5'd8) : (cnt + 5'd8 - two_n);
        end else if ((cnt_pos && (nq3 > 4'd4)) || (cnt_neg && (nq3 < 4'd4))) begin
          word_nxt = {1'b1, q8, ~qm3[7:0]};
          cnt_nxt  = cnt + {3'b000, q8, 1'b0} + 5'd8 - two_n;
        end else begin
          word_nxt = {1'b0, q8, qm3[7:0]};
          cnt_nxt  = cnt + two_n - 5'd8 - {3'b000, ~q8, 1'b0};
        end
      end
      VID_GB:  word_nxt = ((LANE % 2) == 0) ? VID_GB_A : VID_GB_B;
      // Lane 0 carries sync during the data-island guard band.
      DI_GB:   word_nxt = (LANE == 0) ? TERC4_LUT[{2'b11, ctrl}] : VID_GB_B;
      ISLAND:  word_nxt = TERC4_LUT[t3];
      default: word_nxt = CTRL_TOKEN[ctrl];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d1   <= '0;
      n1   <= '0;
      t1   <= '0;
      qm2  <= '0;
      t2   <= '0;
      qm3  <= '0;
      nq3  <= '0;
      t3   <= '0;
      tmds <= '0;
      cnt  <= '0;
    end else begin
      d1   <= data;
      n1   <= popcount8(data);
      t1   <= terc4;
      qm2  <= qm_c;
      t2   <= t1;
      qm3  <= qm2;
      nq3  <= popcount8(qm2[7:0]);
      t3   <= t2;
      tmds <= word_nxt;
      cnt  <= cnt_nxt;
    end
  end

`ifdef TMDS_DISP_MON_EN
  assign disp = cnt;
`endif

endmodule

// File: rtl/tmds_lane_array.sv
// tmds_lane_array: N-lane TMDS/HDMI 1.4 encoder with a fixed four-clock
// latency for every period type, so all lanes stay word-aligned.
//   clk       pixel clock
//   rst       synchronous active-high reset
//   mode_in   mode_t period type shared by all lanes (5..7 act as CTRL)
//   data_in   video byte per lane, lane k at [8k+7:8k]
//   ctrl_in   {c1,c0} per lane; lane 0 = {vsync,hsync}
//   terc4_in  data-island nibble per lane
//   tmds_out  10-bit code word per lane, bit 0 sent first
//   disp_out  per-lane running disparity (only with TMDS_DISP_MON_EN)
// Optional feature macro: TMDS_DISP_MON_EN.
// No valid/ready handshake: a new input set is accepted every clock.
module tmds_lane_array
  import tmds_pkg::*;
#(
  parameter int NUM_CH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           mode_in,
  input  logic [NUM_CH*8-1:0]  data_in,
  input  logic [NUM_CH*2-1:0]  ctrl_in,
  input  logic [NUM_CH*4-1:0]  terc4_in,
  output logic [NUM_CH*10-1:0] tmds_out
`ifdef TMDS_DISP_MON_EN
  ,
  output logic [NUM_CH*5-1:0]  disp_out
`endif
);

  // Lanes implement four register stages; mode/ctrl need LATENCY-1
  // registers here because S4 consumes them combinationally.
  localparam int LATENCY = 4;
  localparam int DLY     = LATENCY - 1;

  mode_t               mode_norm;
  mode_t               mode_q [DLY];
  logic [NUM_CH*2-1:0] ctrl_q [DLY];

  assign mode_norm = (mode_in > 3'd4) ? CTRL : mode_t'(mode_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DLY; i++) begin
        mode_q[i] <= CTRL;
        ctrl_q[i] <= '0;
      end
    end else begin
      mode_q[0] <= mode_norm;
      ctrl_q[0] <= ctrl_in;
      for (int i = 1; i < DLY; i++) begin
        mode_q[i] <= mode_q[i-1];
        ctrl_q[i] <= ctrl_q[i-1];
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    tmds_lane #(
      .LANE(k)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .data  (data_in[8*k +: 8]),
      .terc4 (terc4_in[4*k +: 4]),
      .mode  (mode_q[DLY-1]),
      .ctrl  (ctrl_q[DLY-1][2*k +: 2]),
      .tmds  (tmds_out[10*k +: 10])
`ifdef TMDS_DISP_MON_EN
      ,
      .disp  (disp_out[5*k +: 5])
`endif
    );
  end

endmodule
